// File: rtl/multicycle_control.sv
// multicycle_control
//   Sequencing FSM for the multicycle rvsimple core. It steps each instruction
//   through FETCH/DECODE/EXECUTE/MEM/WRITEBACK and drives the write enables of
//   the PC and instruction registers and the register-file write strobe. It
//   also handshakes with a variable-latency memory and faults on a bounded
//   wait timeout or an illegal opcode.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   FETCH     | read instruction; latch it into the IR when mem_ready
//   DECODE    | one cycle; check the opcode, illegal goes to HALT
//   EXECUTE   | ALU step; branches and fences retire here
//   MEM       | load/store data access, waits on mem_ready; stores retire
//   WRITEBACK | register-file write and PC update
//   HALT      | fault latched; everything idle until reset
//
// Ports
//   clock                 in   system clock, rising edge
//   reset                 in   asynchronous active-low reset
//   opcode[6:0]           in   inst[6:0] from the instruction register
//   take_branch           in   branch comparison result (EXECUTE)
//   mem_ready             in   memory completes the current access
//   pc_write_enable       out  PC register write enable
//   pc_source[1:0]        out  0=pc+4, 1=pc+imm, 2=rs1+imm
//   ir_write_enable       out  instruction register write enable
//   regfile_write_enable  out  register-file write strobe
//   mem_read              out  memory read request
//   mem_write             out  memory write request
//   alu_op_type[1:0]      out  0=add, 1=funct decoded, 2=branch compare
//   fault                 out  sticky fault flag
//   state[2:0]            out  current state code

module multicycle_control #(
    parameter int MAX_WAIT   = 255,
    parameter int WAIT_WIDTH = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       take_branch,
    input  logic       mem_ready,
    output logic       pc_write_enable,
    output logic [1:0] pc_source,
    output logic       ir_write_enable,
    output logic       regfile_write_enable,
    output logic       mem_read,
    output logic       mem_write,
    output logic [1:0] alu_op_type,
    output logic       fault,
    output logic [2:0] state
);

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEM       = 3'd3,
        WRITEBACK = 3'd4,
        HALT      = 3'd5
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [WAIT_WIDTH-1:0] wait_q;
    logic                  fault_q;

    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       is_misc_mem;
    logic       is_legal;
    logic       wait_term;
    logic       waiting;
    logic       pc_we_c;
    logic [1:0] pc_src_c;
    logic       ir_we_c;
    logic       rf_we_c;
    logic       mem_rd_c;
    logic       mem_wr_c;
    logic [1:0] alu_c;

    assign is_load     = (opcode == OPC_LOAD);
    assign is_store    = (opcode == OPC_STORE);
    assign is_branch   = (opcode == OPC_BRANCH);
    assign is_misc_mem = (opcode == OPC_MISC_MEM);
    assign is_legal    = is_load || is_store || is_branch || is_misc_mem ||
                         (opcode == OPC_OP) || (opcode == OPC_OP_IMM) ||
                         (opcode == OPC_JAL) || (opcode == OPC_JALR) ||
                         (opcode == OPC_LUI) || (opcode == OPC_AUIPC);

    // Last permitted wait cycle: one more stalled cycle would exceed MAX_WAIT.
    assign wait_term = (wait_q == WAIT_WIDTH'(MAX_WAIT - 1));

    always_comb begin
        state_d  = state_q;
        waiting  = 1'b0;
        pc_we_c  = 1'b0;
        pc_src_c = 2'd0;
        ir_we_c  = 1'b0;
        rf_we_c  = 1'b0;
        mem_rd_c = 1'b0;
        mem_wr_c = 1'b0;
        alu_c    = 2'd0;
        case (state_q)
            FETCH: begin
                mem_rd_c = 1'b1;
                if (mem_ready) begin
                    ir_we_c = 1'b1;
                    state_d = DECODE;
                end else begin
                    waiting = 1'b1;
                    if (wait_term) state_d = HALT;
                end
            end
            DECODE: begin
                state_d = is_legal ? EXECUTE : HALT;
            end
            EXECUTE: begin
                if (is_branch) alu_c = 2'd2;
                else if ((opcode == OPC_OP) || (opcode == OPC_OP_IMM)) alu_c = 2'd1;
                if (is_branch) begin
                    pc_we_c  = 1'b1;
                    pc_src_c = take_branch ? 2'd1 : 2'd0;
                    state_d  = FETCH;
                end else if (is_misc_mem) begin
                    pc_we_c = 1'b1;
                    state_d = FETCH;
                end else if (is_load || is_store) begin
                    state_d = MEM;
                end else begin
                    state_d = WRITEBACK;
                end
            end
            MEM: begin
                mem_rd_c = is_load;
                mem_wr_c = is_store;
                if (mem_ready) begin
                    if (is_load) begin
                        state_d = WRITEBACK;
                    end else if (is_store) begin
                        pc_we_c = 1'b1;
                        state_d = FETCH;
                    end else begin
                        // opcode changed under a memory access: not recoverable
                        state_d = HALT;
                    end
                end else begin
                    waiting = 1'b1;
                    if (wait_term) state_d = HALT;
                end
            end
            WRITEBACK: begin
                rf_we_c = 1'b1;
                pc_we_c = 1'b1;
                if (opcode == OPC_JAL) pc_src_c = 2'd1;
                else if (opcode == OPC_JALR) pc_src_c = 2'd2;
                state_d = FETCH;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = HALT;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
            wait_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == HALT) fault_q <= 1'b1;
            // A timeout always changes state, so the counter clears before it could wrap.
            if (state_d != state_q) wait_q <= '0;
            else if (waiting) wait_q <= wait_q + 1'b1;
        end
    end

    // Strobes are forced low while reset is held so nothing completes mid-reset.
    assign pc_write_enable      = reset & pc_we_c;
    assign ir_write_enable      = reset & ir_we_c;
    assign regfile_write_enable = reset & rf_we_c;
    assign mem_read             = reset & mem_rd_c;
    assign mem_write            = reset & mem_wr_c;
    assign pc_source            = pc_src_c;
    assign alu_op_type          = alu_c;
    assign fault                = fault_q;
    assign state                = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    localparam int MW = 4;

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] MISC   = 7'b0001111;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] opcode = OP;
    logic       take_branch = 1'b0;
    logic       mem_ready = 1'b1;
    logic       pc_write_enable;
    logic [1:0] pc_source;
    logic       ir_write_enable;
    logic       regfile_write_enable;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] alu_op_type;
    logic       fault;
    logic [2:0] state;

    multicycle_control #(.MAX_WAIT(MW), .WAIT_WIDTH(8)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .take_branch(take_branch),
        .mem_ready(mem_ready), .pc_write_enable(pc_write_enable), .pc_source(pc_source),
        .ir_write_enable(ir_write_enable), .regfile_write_enable(regfile_write_enable),
        .mem_read(mem_read), .mem_write(mem_write), .alu_op_type(alu_op_type),
        .fault(fault), .state(state)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int pc_cnt = 0;
    int rf_cnt = 0;
    int mr_cnt = 0;
    int last_pcsrc = 0;

    // Reference model: position within the instruction's stage route plus wait count.
    int m_pos = 0;
    int m_wait = 0;
    bit m_halt = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [6:0] op);
        return op inside {LOAD, STORE, OP, OPIMM, BRANCH, JAL, JALR, LUI, AUIPC, MISC};
    endfunction

    // Stage codes: 0 fetch, 1 decode, 2 execute, 3 mem, 4 writeback.
    function automatic int route_len(input logic [6:0] op);
        if (!legal(op)) return 2;
        if (op == LOAD) return 5;
        if (op == BRANCH || op == MISC) return 3;
        return 4;
    endfunction

    function automatic int stage_at(input logic [6:0] op, input int pos);
        int r[5];
        r = '{0, 1, 2, 4, 0};
        if (op == LOAD) r = '{0, 1, 2, 3, 4};
        else if (op == STORE) r = '{0, 1, 2, 3, 0};
        return r[pos];
    endfunction

    task automatic model_step();
        int st;
        if (!reset) begin
            m_pos = 0; m_wait = 0; m_halt = 0;
            return;
        end
        if (m_halt) return;
        st = stage_at(opcode, m_pos);
        if ((st == 0 || st == 3) && !mem_ready) begin
            m_wait++;
            if (m_wait == MW) m_halt = 1;
        end else begin
            m_wait = 0;
            if (!legal(opcode) && m_pos == 1) m_halt = 1;
            else begin
                m_pos++;
                if (m_pos == route_len(opcode)) m_pos = 0;
            end
        end
    endtask

    task automatic tick();
        int st, e_mr, e_mw, e_ir, e_pcwe, e_src, e_rf, e_alu, e_fault;
        bit last;
        #1;
        e_mr = 0; e_mw = 0; e_ir = 0; e_pcwe = 0; e_src = 0; e_rf = 0; e_alu = 0; e_fault = 0;
        if (!reset) begin
            st = 0;
        end else if (m_halt) begin
            st = 5; e_fault = 1;
        end else begin
            st = stage_at(opcode, m_pos);
            last = legal(opcode) && (m_pos == route_len(opcode) - 1);
            e_mr = (st == 0 || (st == 3 && opcode == LOAD)) ? 1 : 0;
            e_mw = (st == 3 && opcode == STORE) ? 1 : 0;
            e_ir = (st == 0 && mem_ready) ? 1 : 0;
            e_pcwe = (last && (st != 3 || mem_ready)) ? 1 : 0;
            e_rf = (st == 4) ? 1 : 0;
            if (st == 2) e_alu = (opcode == BRANCH) ? 2 : ((opcode == OP || opcode == OPIMM) ? 1 : 0);
            if (st == 2 && opcode == BRANCH && take_branch) e_src = 1;
            if (st == 4 && opcode == JAL) e_src = 1;
            if (st == 4 && opcode == JALR) e_src = 2;
        end
        chk("state", state, st);
        chk("fault", fault, e_fault);
        chk("mem_read", mem_read, e_mr);
        chk("mem_write", mem_write, e_mw);
        chk("ir_write_enable", ir_write_enable, e_ir);
        chk("pc_write_enable", pc_write_enable, e_pcwe);
        chk("pc_source", pc_source, e_src);
        chk("regfile_write_enable", regfile_write_enable, e_rf);
        chk("alu_op_type", alu_op_type, e_alu);
        if (pc_write_enable) begin pc_cnt++; last_pcsrc = pc_source; end
        if (regfile_write_enable) rf_cnt++;
        if (mem_read) mr_cnt++;
        model_step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    typedef struct {
        logic [6:0] op;
        bit         take;
        int         cycles;
        int         pcsrc;
        int         pcwe;
        int         rf;
        int         end_state;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int n;
        int pc0;
        vecs[0]  = '{OP,     0, 4, 0, 1, 1, 0};
        vecs[1]  = '{OPIMM,  0, 4, 0, 1, 1, 0};
        vecs[2]  = '{LUI,    0, 4, 0, 1, 1, 0};
        vecs[3]  = '{AUIPC,  0, 4, 0, 1, 1, 0};
        vecs[4]  = '{JAL,    0, 4, 1, 1, 1, 0};
        vecs[5]  = '{JALR,   1, 4, 2, 1, 1, 0};
        vecs[6]  = '{STORE,  0, 4, 0, 1, 0, 0};
        vecs[7]  = '{LOAD,   0, 5, 0, 1, 1, 0};
        vecs[8]  = '{BRANCH, 1, 3, 1, 1, 0, 0};
        vecs[9]  = '{BRANCH, 0, 3, 0, 1, 0, 0};
        vecs[10] = '{MISC,   1, 3, 0, 1, 0, 0};
        vecs[11] = '{SYSTEM, 0, 2, 0, 0, 0, 5};

        @(negedge clock);
        do_reset();

        // Zero-wait latency per instruction class.
        foreach (vecs[i]) begin
            opcode = vecs[i].op; take_branch = vecs[i].take; mem_ready = 1'b1;
            pc_cnt = 0; rf_cnt = 0; last_pcsrc = 0; n = 0;
            for (int k = 0; k < 20; k++) begin
                tick(); n++;
                if (state == 3'd0 || state == 3'd5) break;
            end
            chk($sformatf("vec%0d_cycles", i), n, vecs[i].cycles);
            chk($sformatf("vec%0d_end_state", i), state, vecs[i].end_state);
            chk($sformatf("vec%0d_pc_pulses", i), pc_cnt, vecs[i].pcwe);
            chk($sformatf("vec%0d_pcsrc", i), last_pcsrc, vecs[i].pcsrc);
            chk($sformatf("vec%0d_rf_writes", i), rf_cnt, vecs[i].rf);
            if (state == 3'd5) do_reset();
        end

        // OP: explicit state sequence 0,1,2,4 then back to 0.
        opcode = OP; mem_ready = 1'b1;
        chk("seq_op_s0", state, 0); tick();
        chk("seq_op_s1", state, 1); tick();
        chk("seq_op_s2", state, 2); tick();
        chk("seq_op_s3", state, 4); tick();
        chk("seq_op_s4", state, 0);

        // LOAD with three stalled MEM cycles: 8 cycles, mem_read 4 cycles in MEM.
        opcode = LOAD; mem_ready = 1'b1; rf_cnt = 0; n = 0;
        for (int k = 0; k < 3; k++) begin tick(); n++; end
        mr_cnt = 0;
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin tick(); n++; end
        mem_ready = 1'b1;
        tick(); n++;
        chk("load_wait_mem_read_cycles", mr_cnt, 4);
        chk("load_wait_in_wb", state, 4);
        tick(); n++;
        chk("load_wait_total", n, 8);
        chk("load_wait_rf_writes", rf_cnt, 1);

        // FETCH timeout: exactly MW stalled cycles, then sticky fault.
        mem_ready = 1'b0; pc_cnt = 0;
        for (int k = 0; k < MW - 1; k++) tick();
        chk("timeout_not_yet", state, 0);
        tick();
        chk("timeout_halt", state, 5);
        for (int k = 0; k < 3; k++) begin mem_ready = k[0]; tick(); end
        chk("timeout_fault_sticky", fault, 1);
        chk("timeout_no_pc_write", pc_cnt, 0);
        do_reset();
        chk("reset_clears_fault", fault, 0);

        // Handshake on the last permitted wait cycle wins.
        mem_ready = 1'b0; opcode = OP;
        for (int k = 0; k < MW - 1; k++) tick();
        mem_ready = 1'b1;
        tick();
        chk("timeout_edge_decode", state, 1);
        chk("timeout_edge_fault", fault, 0);
        for (int k = 0; k < 3; k++) tick();

        // Reset in the middle of a stalled STORE.
        opcode = STORE; mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        chk("store_in_mem", state, 3);
        mem_ready = 1'b0;
        tick();
        pc0 = pc_cnt;
        reset = 1'b0;
        tick();
        chk("mid_reset_state", state, 0);
        chk("mid_reset_no_pc_write", pc_cnt, pc0);
        reset = 1'b1;
        mem_ready = 1'b1;
        tick();
        chk("after_reset_decode", state, 1);
        for (int k = 0; k < 3; k++) tick();

        // Randomised traffic against the stage-route model.
        for (int c = 0; c < 3000; c++) begin
            if (m_halt || $urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                if (m_pos == 0 && m_wait == 0) begin
                    if ($urandom_range(0, 99) < 90) begin
                        case ($urandom_range(0, 9))
                            0: opcode = LOAD;   1: opcode = STORE;  2: opcode = OP;
                            3: opcode = OPIMM;  4: opcode = BRANCH; 5: opcode = JAL;
                            6: opcode = JALR;   7: opcode = LUI;    8: opcode = AUIPC;
                            default: opcode = MISC;
                        endcase
                    end else begin
                        opcode = 7'($urandom_range(0, 127));
                    end
                end
                mem_ready = ($urandom_range(0, 99) < 75);
                take_branch = $urandom_range(0, 1) == 1;
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
